// File: rtl/rtc_display_scheduler_pkg.sv
// ============================================================================
// rtc_display_scheduler_pkg: shared FSM states, RTC addresses, BCD limits.
// Rev 1.0
// ============================================================================
`default_nettype none

package rtc_display_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_NEXT    = 3'd2,
    ST_CHECK   = 3'd3,
    ST_WAIT_VB = 3'd4,
    ST_COMMIT  = 3'd5
  } state_t;

  localparam logic [7:0] DEF_ADDR_SEC  = 8'h21;
  localparam logic [7:0] DEF_ADDR_MIN  = 8'h22;
  localparam logic [7:0] DEF_ADDR_HOUR = 8'h23;
  localparam logic [6:0] DEF_CHAR_BASE = 7'h30;

  localparam logic [7:0] BCD_MS_LIMIT   = 8'h60;
  localparam logic [7:0] BCD_HOUR_LIMIT = 8'h24;

endpackage

`default_nettype wire

// File: rtl/rtc_display_scheduler_bcd_digit_char.sv
// ============================================================================
// bcd_digit_char: maps one BCD nibble to its font-ROM character code.
// Rev 1.0
// ============================================================================
`default_nettype none

module bcd_digit_char
  import rtc_display_scheduler_pkg::*;
#(
  parameter logic [6:0] CHAR_BASE = DEF_CHAR_BASE
) (
  input  logic [3:0] nibble,
  output logic [6:0] code
);

  assign code = CHAR_BASE + {3'b000, nibble};

endmodule

`default_nettype wire

// File: rtl/rtc_display_scheduler.sv
// ============================================================================
// rtc_display_scheduler: polls RTC sec/min/hour, validates BCD, commits the six
// character codes at vblank rise. Optional macro RTC_TIMEOUT_EN: ack timeout.
// Rev 1.0
// ============================================================================
`default_nettype none

module rtc_display_scheduler
  import rtc_display_scheduler_pkg::*;
#(
  parameter int         POLL_DIV  = 50000000,
  parameter logic [7:0] ADDR_SEC  = DEF_ADDR_SEC,
  parameter logic [7:0] ADDR_MIN  = DEF_ADDR_MIN,
  parameter logic [7:0] ADDR_HOUR = DEF_ADDR_HOUR,
  parameter logic [6:0] CHAR_BASE = DEF_CHAR_BASE,
  parameter int         TIMEOUT   = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       vblank,
  output logic       req,
  output logic [7:0] req_addr,
  input  logic       ack,
  input  logic [7:0] rd_data,
  output logic [6:0] sec_u,
  output logic [6:0] sec_d,
  output logic [6:0] min_u,
  output logic [6:0] min_d,
  output logic [6:0] hour_u,
  output logic [6:0] hour_d,
  output logic       busy,
  output logic       update,
  output logic       err
);

  localparam int CW = $clog2(POLL_DIV);

  state_t        state;
  logic [CW-1:0] poll_cnt;
  logic          tick;
  logic [1:0]    idx;
  logic [6:0]    sh_sec;
  logic [6:0]    sh_min;
  logic [5:0]    sh_hour;
  logic          vb_prev;
  logic          vb_rise;
  logic          bcd_bad;
  logic          timed_out;
  logic [3:0]    nib  [6];
  logic [6:0]    code [6];
  logic          unused_rd;

  // Bit 7 of every RTC register is a control/format bit outside all masks.
  assign unused_rd = rd_data[7];

  assign tick = (poll_cnt == CW'(POLL_DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset_n || tick) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + 1'b1;
    end
  end

`ifdef RTC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;

  // Held at zero outside REQ, so every entry to REQ starts a fresh count.
  always_ff @(posedge clk) begin
    if (!reset_n || state != ST_REQ) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timed_out = (wait_cnt == TW'(TIMEOUT - 1));
`else
  localparam int unused_timeout = TIMEOUT;
  assign timed_out = 1'b0;
`endif

  assign vb_rise = vblank & ~vb_prev;

  assign bcd_bad = (sh_sec[3:0]  > 4'd9) ||
                   (sh_min[3:0]  > 4'd9) ||
                   (sh_hour[3:0] > 4'd9) ||
                   ({1'b0, sh_sec}   >= BCD_MS_LIMIT) ||
                   ({1'b0, sh_min}   >= BCD_MS_LIMIT) ||
                   ({2'b00, sh_hour} >= BCD_HOUR_LIMIT);

  assign nib[0] = sh_sec[3:0];
  assign nib[1] = {1'b0, sh_sec[6:4]};
  assign nib[2] = sh_min[3:0];
  assign nib[3] = {1'b0, sh_min[6:4]};
  assign nib[4] = sh_hour[3:0];
  assign nib[5] = {2'b00, sh_hour[5:4]};

  generate
    for (genvar g = 0; g < 6; g++) begin : g_digit
      bcd_digit_char #(
        .CHAR_BASE(CHAR_BASE)
      ) u_char (
        .nibble(nib[g]),
        .code  (code[g])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      idx      <= 2'd0;
      sh_sec   <= '0;
      sh_min   <= '0;
      sh_hour  <= '0;
      vb_prev  <= 1'b0;
      req      <= 1'b0;
      req_addr <= ADDR_SEC;
      busy     <= 1'b0;
      update   <= 1'b0;
      err      <= 1'b0;
      sec_u    <= CHAR_BASE;
      sec_d    <= CHAR_BASE;
      min_u    <= CHAR_BASE;
      min_d    <= CHAR_BASE;
      hour_u   <= CHAR_BASE;
      hour_d   <= CHAR_BASE;
    end else begin
      vb_prev <= vblank;
      update  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tick) begin
            state    <= ST_REQ;
            idx      <= 2'd0;
            busy     <= 1'b1;
            req      <= 1'b1;
            req_addr <= ADDR_SEC;
          end
        end
        ST_REQ: begin
          if (ack) begin
            case (idx)
              2'd0:    sh_sec  <= rd_data[6:0];
              2'd1:    sh_min  <= rd_data[6:0];
              default: sh_hour <= rd_data[5:0];
            endcase
            req   <= 1'b0;
            state <= ST_NEXT;
          end else if (timed_out) begin
            req   <= 1'b0;
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_NEXT: begin
          if (idx != 2'd2) begin
            idx      <= idx + 2'd1;
            req_addr <= (idx == 2'd0) ? ADDR_MIN : ADDR_HOUR;
            req      <= 1'b1;
            state    <= ST_REQ;
          end else begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (bcd_bad) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            state <= ST_WAIT_VB;
          end
        end
        ST_WAIT_VB: begin
          // Digits land on the edge that detects the rise, so they are stable
          // for the whole blanking interval.
          if (vb_rise) begin
            sec_u  <= code[0];
            sec_d  <= code[1];
            min_u  <= code[2];
            min_d  <= code[3];
            hour_u <= code[4];
            hour_d <= code[5];
            update <= 1'b1;
            err    <= 1'b0;
            busy   <= 1'b0;
            state  <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rtc_display_scheduler.sv
// ============================================================================
// tb_rtc_display_scheduler: table + random polls against a decimal-value model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rtc_display_scheduler;

  localparam int POLL_DIV = 64;
  localparam int TIMEOUT  = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       vblank = 1'b0;
  logic       ack = 1'b0;
  logic [7:0] rd_data = 8'h00;
  logic       req, busy, update, err;
  logic [7:0] req_addr;
  logic [6:0] sec_u, sec_d, min_u, min_d, hour_u, hour_d;
  wire  [41:0] dig = {hour_d, hour_u, min_d, min_u, sec_d, sec_u};

  always #5 clk = ~clk;

  rtc_display_scheduler #(
    .POLL_DIV(POLL_DIV),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .vblank  (vblank),
    .req     (req),
    .req_addr(req_addr),
    .ack     (ack),
    .rd_data (rd_data),
    .sec_u   (sec_u),
    .sec_d   (sec_d),
    .min_u   (min_u),
    .min_d   (min_d),
    .hour_u  (hour_u),
    .hour_d  (hour_d),
    .busy    (busy),
    .update  (update),
    .err     (err)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int upd_seen = 0;
  logic [41:0] cur_disp;
  bit          model_err;
  localparam logic [41:0] ZERO_DISP = {6{7'h30}};

  always @(posedge clk) if (update === 1'b1) upd_seen++;

  typedef struct {
    logic [7:0]  s;
    logic [7:0]  m;
    logic [7:0]  h;
    bit          vb_early;
    bit          ok;
    logic [41:0] exp;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: decode BCD into decimal values and judge by numeric range.
  function automatic bit field_ok(input logic [7:0] v, input int tens_bits, input int limit);
    int ones = int'(v[3:0]);
    int tens = int'(v[7:4]) & ((1 << tens_bits) - 1);
    return (ones <= 9) && (tens <= 9) && (tens * 10 + ones < limit);
  endfunction

  function automatic bit model_ok(input logic [7:0] s, m, h);
    return field_ok(s, 3, 60) && field_ok(m, 3, 60) && field_ok(h, 2, 24);
  endfunction

  function automatic logic [6:0] ch(input int n);
    return 7'(48 + n);
  endfunction

  function automatic logic [41:0] model_disp(input logic [7:0] s, m, h);
    return {ch(int'(h[5:4])), ch(int'(h[3:0])), ch(int'(m[6:4])), ch(int'(m[3:0])),
            ch(int'(s[6:4])), ch(int'(s[3:0]))};
  endfunction

  function automatic logic [7:0] rnd_field(input int limit, input logic [7:0] junk);
    int v;
    if ($urandom_range(0, 3) != 0) begin
      v = int'($urandom_range(0, limit - 1));
      return 8'(((v / 10) << 4) | (v % 10)) | (8'($urandom) & junk);
    end
    return 8'($urandom);
  endfunction

  task automatic wait_req(input string name);
    int k = 0;
    while (req !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(name, req, 1);
  endtask

  task automatic run_poll(input logic [7:0] s, m, h, input int dly, input bit vb_early,
                          input int vb_wait, input bit ok, input logic [41:0] exp);
    logic [7:0] d[3];
    logic [7:0] a[3];
    int u0;
    d[0] = s; d[1] = m; d[2] = h;
    a[0] = 8'h21; a[1] = 8'h22; a[2] = 8'h23;
    for (int i = 0; i < 3; i++) begin
      wait_req("req_arrive");
      if (i == 0) begin
        chk("busy_at_req", busy, 1);
        chk("err_sticky", err, model_err);
      end
      chk("req_addr", req_addr, a[i]);
      repeat (dly) @(negedge clk);
      chk("req_hold", {req, req_addr}, {1'b1, a[i]});
      ack = 1'b1;
      rd_data = d[i];
      @(negedge clk);
      ack = 1'b0;
      rd_data = 8'($urandom);
      chk("req_drop", req, 0);
      @(negedge clk);
      if (i < 2) chk("ack_to_req", req, 1);
    end
    if (vb_early) vblank = 1'b1;
    @(negedge clk);
    u0 = upd_seen;
    if (!ok) begin
      chk("bad_err", err, 1);
      chk("bad_busy", busy, 0);
      chk("bad_hold", dig, cur_disp);
      vblank = 1'b1;
      repeat (3) @(negedge clk);
      vblank = 1'b0;
      repeat (2) @(negedge clk);
      chk("bad_no_update", upd_seen - u0, 0);
      chk("bad_hold2", dig, cur_disp);
      model_err = 1'b1;
    end else begin
      chk("wait_busy", busy, 1);
      if (vb_early) begin
        repeat (10) @(negedge clk);
        chk("vbhigh_no_update", upd_seen - u0, 0);
        chk("vbhigh_hold", dig, cur_disp);
        vblank = 1'b0;
        repeat (3) @(negedge clk);
        chk("vbfall_hold", dig, cur_disp);
      end else begin
        repeat (vb_wait) @(negedge clk);
        chk("prevb_hold", dig, cur_disp);
        chk("prevb_busy", busy, 1);
      end
      vblank = 1'b1;
      @(negedge clk);
      chk("commit_update", update, 1);
      chk("commit_digits", dig, exp);
      chk("commit_err", err, 0);
      chk("commit_busy", busy, 0);
      @(negedge clk);
      chk("update_pulse_end", update, 0);
      vblank = 1'b0;
      chk("update_once", upd_seen - u0, 1);
      cur_disp  = exp;
      model_err = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int hi;
    logic [7:0] rs, rm, rh;
    vecs[0] = '{8'h45, 8'h37, 8'h12, 1'b0, 1'b1, {7'h31, 7'h32, 7'h33, 7'h37, 7'h34, 7'h35}};
    vecs[1] = '{8'h5A, 8'h00, 8'h00, 1'b0, 1'b0, 42'h0};
    vecs[2] = '{8'h59, 8'h59, 8'h23, 1'b0, 1'b1, {7'h32, 7'h33, 7'h35, 7'h39, 7'h35, 7'h39}};
    vecs[3] = '{8'h60, 8'h00, 8'h00, 1'b0, 1'b0, 42'h0};
    vecs[4] = '{8'h00, 8'h00, 8'h24, 1'b0, 1'b0, 42'h0};
    vecs[5] = '{8'h00, 8'h00, 8'h00, 1'b1, 1'b1, {6{7'h30}}};
    vecs[6] = '{8'hD9, 8'hB9, 8'hE3, 1'b0, 1'b1, {7'h32, 7'h33, 7'h33, 7'h39, 7'h35, 7'h39}};
    vecs[7] = '{8'h09, 8'h5F, 8'h00, 1'b0, 1'b0, 42'h0};

    repeat (3) @(negedge clk);
    chk("rst_digits", dig, ZERO_DISP);
    chk("rst_req", req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_update", update, 0);
    chk("rst_addr", req_addr, 8'h21);
    cur_disp  = ZERO_DISP;
    model_err = 1'b0;
    reset_n   = 1'b1;

    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (req !== 1'b1 && k < 200);
    chk("first_req_cycles", k, POLL_DIV);

    foreach (vecs[i]) begin
      run_poll(vecs[i].s, vecs[i].m, vecs[i].h, 5, vecs[i].vb_early, 20,
               vecs[i].ok, vecs[i].ok ? vecs[i].exp : cur_disp);
    end

    for (int i = 0; i < 12; i++) begin
      rs = rnd_field(60, 8'h80);
      rm = rnd_field(60, 8'h80);
      rh = rnd_field(24, 8'hC0);
      run_poll(rs, rm, rh, int'($urandom_range(0, 10)), bit'($urandom_range(0, 1)),
               int'($urandom_range(1, 15)), model_ok(rs, rm, rh),
               model_ok(rs, rm, rh) ? model_disp(rs, rm, rh) : cur_disp);
    end

    run_poll(8'h56, 8'h34, 8'h12, 2, 1'b0, 4, 1'b1,
             {7'h31, 7'h32, 7'h33, 7'h34, 7'h35, 7'h36});

    // Reset while the minutes read is outstanding.
    wait_req("mid_req0");
    chk("mid_addr0", req_addr, 8'h21);
    repeat (2) @(negedge clk);
    ack = 1'b1; rd_data = 8'h11;
    @(negedge clk);
    ack = 1'b0;
    wait_req("mid_req1");
    chk("mid_addr1", req_addr, 8'h22);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_req", req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_digits", dig, ZERO_DISP);
    chk("mid_rst_err", err, 0);
    reset_n   = 1'b1;
    cur_disp  = ZERO_DISP;
    model_err = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (req !== 1'b1 && k < 200);
    chk("restart_cycles", k, POLL_DIV);
    chk("restart_addr", req_addr, 8'h21);
    run_poll(8'h07, 8'h08, 8'h09, 1, 1'b0, 3, 1'b1,
             {7'h30, 7'h39, 7'h30, 7'h38, 7'h30, 7'h37});

    // Ack withheld.
    wait_req("nack_req");
`ifdef RTC_TIMEOUT_EN
    hi = 1;
    while (hi < 100) begin
      @(negedge clk);
      if (req !== 1'b1) break;
      hi++;
    end
    chk("timeout_req_cycles", hi, TIMEOUT);
    chk("timeout_err", err, 1);
    chk("timeout_busy", busy, 0);
    chk("timeout_hold", dig, cur_disp);
`else
    hi = 0;
    repeat (1000) begin
      @(negedge clk);
      if (req === 1'b1) hi++;
    end
    chk("req_held", hi, 1000);
    chk("nack_busy", busy, 1);
    chk("nack_err", err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rtc_display_scheduler.md
Name: rtc_display_scheduler

Overview:
- Periodically reads seconds, minutes and hours from the RTC through the bus-driver request/ack handshake.
- Validates the BCD values and converts each digit to a font-ROM character code.
- Commits all six digit registers atomically at the start of vertical blank, so the on-screen time overlay never tears mid-frame.
- Sits between the RTC bus driver and the text-overlay/pixel-generation block.

Parameters:
- POLL_DIV, 50000000, clock cycles between poll ticks (0.5 s at 100 MHz); must be >= 64.
- ADDR_SEC, 8'h21, RTC register address of seconds.
- ADDR_MIN, 8'h22, RTC register address of minutes.
- ADDR_HOUR, 8'h23, RTC register address of hours.
- CHAR_BASE, 7'h30, font-ROM character code of digit '0'.
- TIMEOUT, 255, maximum ack wait in cycles (used only with RTC_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous reset, active low
- vblank  in  1  high during vertical blanking, from the VGA sync generator
- req  out  1  read request to the RTC bus driver
- req_addr  out  8  register address for the current request
- ack  in  1  one-cycle pulse from the bus driver; rd_data is valid in the same cycle
- rd_data  in  8  BCD register value read from the RTC
- sec_u, sec_d, min_u, min_d, hour_u, hour_d  out  7 each  character codes for the overlay
- busy  out  1  high from the start of a read sequence until commit or abort
- update  out  1  one-cycle pulse in the cycle the digit outputs change
- err  out  1  sticky error flag; cleared by reset or by the next successful commit

Behaviour:
- Reset (reset_n=0 at a clk edge) does all of the following:
  - all digit outputs = CHAR_BASE (display "00:00:00");
  - req, busy, update, err = 0; req_addr = ADDR_SEC;
  - poll counter = 0; FSM returns to IDLE, even mid-transaction.
- Poll counter:
  - free-runs 0..POLL_DIV-1 and wraps;
  - raises tick for one cycle at the wrap;
  - a tick arriving while the FSM is not IDLE is dropped, not queued.
- FSM states: IDLE, REQ, NEXT, CHECK, WAIT_VB, COMMIT.
  - IDLE: on tick -> REQ. Set idx=0, busy=1, req_addr=ADDR_SEC.
  - REQ: req=1 and req_addr stable until ack.
    - On ack: capture rd_data into shadow[idx]; req drops in the next cycle.
    - Go to NEXT.
  - NEXT:
    - idx<2: idx+1, req_addr = ADDR_MIN or ADDR_HOUR -> REQ.
    - idx=2 -> CHECK.
  - CHECK: masks are sec [6:0], min [6:0], hour [5:0]; masked-off bits are ignored.
    - Any nibble > 9, sec or min >= 8'h60, or hour >= 8'h24 -> err=1, busy=0 -> IDLE. Outputs unchanged.
    - Otherwise -> WAIT_VB.
  - WAIT_VB: wait for the vblank rising edge (vblank=1 with the registered previous value 0).
    - vblank already high on entry does not qualify; wait for the next frame.
  - COMMIT: for one cycle:
    - each digit output = CHAR_BASE + nibble (7-bit add, no overflow since nibble <= 9);
    - update=1, err=0, busy=0 -> IDLE.
- Latency:
  - tick to first req = 1 cycle;
  - ack to next req = 2 cycles;
  - vblank edge detection to output change = 1 cycle.
- A minimum sequence is 3 acks plus CHECK plus COMMIT.
- req never asserts while busy=0. At most one outstanding request.
- ack outside REQ is ignored.

Optional Feature:
- Macro: RTC_TIMEOUT_EN.
- Defined:
  - a wait counter in REQ counts cycles without ack;
  - reaching TIMEOUT -> req=0, err=1, busy=0 -> IDLE, outputs unchanged;
  - the counter clears on every entry to REQ.
- Not defined: REQ waits indefinitely and err is set only by CHECK failures.

Decomposition:
- Shared package contents:
  - FSM state enum typedef;
  - RTC register addresses (ADDR_SEC/MIN/HOUR defaults);
  - CHAR_BASE;
  - BCD limit constants (8'h60, 8'h24).
- One natural sub-module: bcd_digit_char.
  - Combinational: 4-bit nibble -> 7-bit code CHAR_BASE+nibble.
  - Instantiated six times.

Test Plan:
- Reset sequence: hold reset_n=0 for 3 cycles -> all digits 7'h30, req=0, busy=0, err=0.
- Nominal poll: POLL_DIV=64; return rd_data 8'h45, 8'h37, 8'h12, each ack after 5 cycles; raise vblank 20 cycles later:
  - req_addr sequence 21, 22, 23;
  - update pulses once, exactly 1 cycle after the vblank edge is detected;
  - sec_u=7'h35, sec_d=7'h34, min_u=7'h37, min_d=7'h33, hour_u=7'h32, hour_d=7'h31.
- vblank already high when CHECK passes: no commit until vblank falls and rises again; outputs hold their old values throughout.
- Invalid BCD: seconds=8'h5A -> err=1, no update pulse, outputs unchanged. The next valid poll commits and clears err.
- Reset mid-sequence: reset_n=0 while in REQ for the minutes read -> req=0 next cycle, busy=0, digits back to 7'h30; the next tick restarts at ADDR_SEC.
- With RTC_TIMEOUT_EN and TIMEOUT=16, ack withheld -> req drops after 16 cycles, err=1, busy=0. Without the macro, req stays high for at least 1000 cycles.
